// File: rtl/ones_vector_enumerator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ones_vector_enumerator                                          |
// | Purpose  : Emits every WIDTH-bit vector holding exactly k set bits, in     |
// |            ascending numeric order, one vector per valid/ready handshake.  |
// | Options  : ONES_ENUM_SELFCHECK_EN adds a popcount/ordering checker and the |
// |            sticky chk_err output.                                          |
// | Revision : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+

`ifdef ONES_ENUM_SELFCHECK_EN
// Population count of a WIDTH-bit vector.
module countOnes #(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0]         in_i,
  output logic [$clog2(WIDTH+1)-1:0] cnt_o
);
  localparam int CW = $clog2(WIDTH+1);

  // Plain accumulate over all bit positions
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_o = cnt_o + CW'(in_i[i]);
    end
  end
endmodule
`endif

module ones_vector_enumerator #(
  parameter  int WIDTH = 5,
  localparam int KW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KW-1:0]    k,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] vec,
  output logic [WIDTH-1:0] idx,
  output logic             last,
  output logic             busy,
  output logic             err
`ifdef ONES_ENUM_SELFCHECK_EN
  ,
  output logic             chk_err
`endif
);

  // Shift amount must reach WIDTH+2 (trailing-zero count plus two).
  localparam int            SW      = KW + 1;
  localparam logic [KW:0]   WIDTH_K = (KW+1)'(WIDTH);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   vec_q, vec_d;
  logic [WIDTH-1:0]   idx_q, idx_d;
  logic               last_q, last_d;
  logic [KW-1:0]      k_q, k_d;
  logic               err_q, err_d;

  // k ones packed at the LSB end: the first vector of a sequence.
  function automatic logic [WIDTH-1:0] low_ones(input logic [KW-1:0] kk);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i < int'(kk));
    end
    return m;
  endfunction

  // k ones packed at the MSB end: the final vector of a sequence.
  function automatic logic [WIDTH-1:0] high_ones(input logic [KW-1:0] kk);
    logic [WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < WIDTH; i++) begin
      m[i] = (i >= (WIDTH - int'(kk)));
    end
    return m;
  endfunction

  // Index of the lowest set bit (priority encoder, LSB wins).
  function automatic logic [SW-1:0] trailing_zeros(input logic [WIDTH:0] c);
    logic [SW-1:0] t;
    t = '0;
    for (int i = WIDTH; i >= 0; i--) begin
      if (c[i]) t = SW'(i);
    end
    return t;
  endfunction

  // Successor with the same popcount (Gosper's hack, divide replaced by shift)
  logic [WIDTH:0]  w_v, w_c, w_r, w_spill, w_next;
  logic [SW-1:0]   w_shamt;
  logic            w_next_is_last;

  always_comb begin
    w_v            = {1'b0, vec_q};
    w_c            = w_v & (-w_v);
    w_r            = w_v + w_c;
    w_shamt        = trailing_zeros(w_c) + SW'(2);
    w_spill        = (w_r ^ w_v) >> w_shamt;
    w_next         = w_r | w_spill;
    w_next_is_last = (w_next == {1'b0, high_ones(k_q)});
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      vec_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state: accept start in IDLE, step the sequence on each handshake in RUN
  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    idx_d   = idx_q;
    last_d  = last_q;
    k_d     = k_q;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if ({1'b0, k} <= WIDTH_K) begin
            state_d = S_RUN;
            k_d     = k;
            vec_d   = low_ones(k);
            idx_d   = '0;
            last_d  = (k == '0) || ({1'b0, k} == WIDTH_K);
          end else begin
            err_d   = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (out_rdy) begin
          if (last_q) begin
            // Sequence finished; clear the output registers for a clean IDLE.
            state_d = S_IDLE;
            vec_d   = '0;
            idx_d   = '0;
            last_d  = 1'b0;
          end else begin
            vec_d   = w_next[WIDTH-1:0];
            idx_d   = idx_q + WIDTH'(1);
            last_d  = w_next_is_last;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign out_vld = (state_q == S_RUN);
  assign busy    = (state_q == S_RUN);
  assign vec     = vec_q;
  assign idx     = idx_q;
  assign last    = last_q;
  assign err     = err_q;

`ifdef ONES_ENUM_SELFCHECK_EN
  logic [KW-1:0]    w_cnt;
  logic             w_hs;
  logic             prev_vld_q;
  logic [WIDTH-1:0] prev_vec_q;
  logic             chk_err_q;

  countOnes #(.WIDTH(WIDTH)) u_count (
    .in_i  (vec_q),
    .cnt_o (w_cnt)
  );

  assign w_hs = (state_q == S_RUN) && out_rdy;

  // Sticky flag: wrong popcount or non-increasing vector on any handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_vld_q <= 1'b0;
      prev_vec_q <= '0;
      chk_err_q  <= 1'b0;
    end else if (w_hs) begin
      prev_vld_q <= !last_q;
      prev_vec_q <= vec_q;
      if ((w_cnt != k_q) || (prev_vld_q && (vec_q <= prev_vec_q))) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign chk_err = chk_err_q;
`else
  // Checker not built: no extra state and no chk_err port.
`endif

endmodule
`default_nettype wire
